// File: rtl/packet_assembler.sv
// packet_assembler: rebuilds 32-bit words from per-source byte flits and queues them on a ready/valid port
module packet_assembler #(
    parameter int NODE_COUNT      = 8,
    parameter int NODE_DEST_CODE  = 0,
    parameter int QUEUE_DEPTH     = 8,
    parameter int PACKET_ID_WIDTH = 5,
    localparam int NW = $clog2(NODE_COUNT),
    localparam int PW = PACKET_ID_WIDTH,
    localparam int FW = 1 + 2*NW + 8 + PW + 2,
    localparam int AW = $clog2(QUEUE_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [FW-1:0] flit_in,
    input  logic          flit_valid,
    output logic [31:0]   word_out,
    output logic [NW-1:0] word_src,
    output logic [PW-1:0] word_id,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [CW-1:0] fifo_count,
    output logic          err_seq,
    output logic          err_misroute,
    output logic          err_overflow
);
    localparam int EW = 32 + NW + PW;
    typedef enum logic {S_IDLE, S_BUSY} slot_state_t;
    logic          f_vld;
    logic [NW-1:0] f_dest;
    logic [NW-1:0] f_src;
    logic [7:0]    f_byte;
    logic [PW-1:0] f_id;
    logic [1:0]    f_idx;
    slot_state_t   st_q   [NODE_COUNT];
    logic [1:0]    exp_q  [NODE_COUNT];
    logic [PW-1:0] id_q   [NODE_COUNT];
    logic [23:0]   data_q [NODE_COUNT];
    slot_state_t   st_d;
    logic [1:0]    exp_d;
    logic [1:0]    cur_exp;
    logic [PW-1:0] id_d;
    logic [23:0]   cur_data;
    logic [23:0]   data_d;
    logic          accept;
    logic          misroute;
    logic          take;
    logic          seq_ok;
    logic          in_order;
    logic          complete;
    logic          seq_bad;
    logic [EW-1:0] mem [QUEUE_DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          pop;
    logic          push_ok;
    logic          overflow;

    assign {f_vld, f_dest, f_byte, f_id, f_src, f_idx} = flit_in;
    assign accept   = flit_valid & f_vld & ce;
    assign misroute = accept & (f_dest != NW'(NODE_DEST_CODE));
    assign take     = accept & ~misroute;

    // An idle slot always expects idx 0; an out-of-order idx 0 restarts the slot instead of dropping it
    always_comb begin
        cur_exp  = (st_q[f_src] == S_BUSY) ? exp_q[f_src] : 2'd0;
        cur_data = data_q[f_src];
        seq_ok   = (f_idx == cur_exp) && ((f_idx == 2'd0) || (f_id == id_q[f_src]));
        in_order = seq_ok || (f_idx == 2'd0);
        st_d     = (in_order && (f_idx != 2'd3)) ? S_BUSY : S_IDLE;
        exp_d    = in_order ? f_idx + 2'd1 : 2'd0;
        id_d     = (f_idx == 2'd0) ? f_id : id_q[f_src];
        data_d   = (f_idx == 2'd0) ? {f_byte, cur_data[15:0]} :
                   (f_idx == 2'd1) ? {cur_data[23:16], f_byte, cur_data[7:0]} :
                   (f_idx == 2'd2) ? {cur_data[23:8], f_byte} : cur_data;
        complete = take & seq_ok & (f_idx == 2'd3);
        seq_bad  = take & ~seq_ok;
    end

    assign word_valid = count_q != '0;
    assign pop        = word_valid & word_ready & ce;
    assign push_ok    = complete & ((count_q < CW'(QUEUE_DEPTH)) | pop);
    assign overflow   = complete & ~push_ok;
    assign head       = word_valid ? mem[rd_ptr] : '0;
    assign {word_out, word_src, word_id} = head;
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODE_COUNT; i++) st_q[i] <= S_IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count_q      <= '0;
            err_seq      <= 1'b0;
            err_misroute <= 1'b0;
            err_overflow <= 1'b0;
        end else if (ce) begin
            if (take) st_q[f_src] <= st_d;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count_q      <= count_q + CW'(push_ok) - CW'(pop);
            err_seq      <= seq_bad;
            err_misroute <= misroute;
            err_overflow <= overflow;
        end
    end

    // Payload storage needs no reset: slot state and FIFO count gate every use of it
    always_ff @(posedge clk) begin
        if (ce && take) begin
            exp_q[f_src]  <= exp_d;
            id_q[f_src]   <= id_d;
            data_q[f_src] <= data_d;
        end
        if (ce && push_ok) mem[wr_ptr] <= {cur_data, f_byte, f_src, id_q[f_src]};
    end
endmodule
